// File: rtl/nkmd_progrom_loader.sv
// NKMD program memory: synchronous RAM with a registered fetch port and a burst loader.
// Optional XOR checksum output csum_o when NKMD_PROGROM_CHECKSUM_EN is defined.
module nkmd_progrom_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    input  logic                  cmd_valid_i,
    input  logic [ADDR_WIDTH-1:0] cmd_base_i,
    input  logic [ADDR_WIDTH:0]   cmd_len_i,
    output logic                  cmd_ready_o,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef NKMD_PROGROM_CHECKSUM_EN
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] csum_o
`else
    output logic                  err_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_cmd_accept;
    logic                  w_wr_accept;
    logic                  w_last;
    logic [ADDR_WIDTH+1:0] w_end;
    logic                  w_overflow;

    assign w_cmd_accept = cmd_valid_i && cmd_ready_o;
    assign w_wr_accept  = wr_valid_i && wr_ready_o && !rst;
    assign w_last       = (r_remain == (ADDR_WIDTH+1)'(1));
    // One extra bit beyond base+len so a full-depth load from a nonzero base is caught.
    assign w_end        = {2'b00, cmd_base_i} + {1'b0, cmd_len_i};
    assign w_overflow   = (w_end > (ADDR_WIDTH+2)'(DEPTH));

    // NOTE: RAM storage has no reset so it maps onto block RAM; only the read register resets.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_ptr] <= wr_data_i;
        end
    end

    // NOTE: non-blocking read and write in the same edge give read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else begin
            data_o <= r_mem[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remain    <= '0;
            cmd_ready_o <= 1'b1;
            wr_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            stall_o     <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_cmd_accept) begin
                        err_o <= w_overflow;
                        if (cmd_len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            r_ptr       <= cmd_base_i;
                            r_remain    <= cmd_len_i;
                            r_state     <= S_LOAD;
                            cmd_ready_o <= 1'b0;
                            wr_ready_o  <= 1'b1;
                            busy_o      <= 1'b1;
                            stall_o     <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_wr_accept) begin
                        r_ptr    <= r_ptr + ADDR_WIDTH'(1);
                        r_remain <= r_remain - (ADDR_WIDTH+1)'(1);
                        if (w_last) begin
                            r_state     <= S_DONE;
                            done_o      <= 1'b1;
                            cmd_ready_o <= 1'b1;
                            wr_ready_o  <= 1'b0;
                            busy_o      <= 1'b0;
                            stall_o     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NKMD_PROGROM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || w_cmd_accept) begin
            r_csum <= '0;
        end else if (w_wr_accept) begin
            r_csum <= r_csum ^ wr_data_i;
        end
    end

    assign csum_o = r_csum;
`endif

endmodule
